// File: rtl/key_shift_rx_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | key_shift_rx_pkg : shared shift-register FSM encodings and timing.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package key_shift_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_FIN      = 3'd4
  } shift_state_e;

  localparam int unsigned C_CLK_DIV_DEFAULT     = 4;
  localparam int unsigned C_SCAN_PERIOD_DEFAULT = 100000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : key_shift_rx_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | key_debounce : scan-to-scan stability filter for the captured vector.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module key_debounce
  import key_shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fin_i,
  input  logic [WIDTH-1:0] shift_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             chg_o
);

  localparam int unsigned     CW    = cnt_width(DEBOUNCE + 1);
  localparam logic [CW-1:0]   C_SAT = CW'(DEBOUNCE);

  logic [CW-1:0]    stab_q;
  logic [CW-1:0]    stab_d;
  logic [WIDTH-1:0] dout_q;
  logic             chg_q;

  // raw_i still holds the previous scan here, so a mismatch restarts the run.
  always_comb begin
    stab_d = stab_q;
    if (shift_i != raw_i) begin
      stab_d = CW'(1);
    end else if (stab_q == C_SAT) begin
      stab_d = C_SAT;
    end else begin
      stab_d = stab_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
      dout_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (fin_i) begin
        stab_q <= stab_d;
        if ((stab_d == C_SAT) && (shift_i != dout_q)) begin
          dout_q <= shift_i;
          chg_q  <= 1'b1;
        end
      end
    end
  end

  assign dout_o = dout_q;
  assign chg_o  = chg_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_shift_rx.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | key_shift_rx : periodic 165-style PISO reader with debounced output.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module key_shift_rx
  import key_shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CLK_DIV     = C_CLK_DIV_DEFAULT,
  parameter int unsigned SCAN_PERIOD = C_SCAN_PERIOD_DEFAULT,
  parameter int unsigned DEBOUNCE    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en_i,
  input  logic             scan_req_i,
  input  logic             sft_q_i,
  output logic             sft_pl_o,
  output logic             sft_shcp_o,
  output logic [WIDTH-1:0] raw_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             done_o,
  output logic             chg_o,
  output logic             busy_o
);

  localparam int unsigned   DW         = cnt_width(CLK_DIV);
  localparam int unsigned   IW         = cnt_width(WIDTH);
  localparam int unsigned   TW         = cnt_width(SCAN_PERIOD);
  localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] C_IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [TW-1:0] C_TMR_LAST = TW'(SCAN_PERIOD - 1);

  shift_state_e     state_q;
  logic [DW-1:0]    div_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] raw_q;
  logic             pend_q;
  logic             busy_q;
  logic             done_q;
  logic             pl_q;
  logic             shcp_q;
  logic [TW-1:0]    tmr_q;
  logic [TW-1:0]    tmr_d;
  logic             tick_w;
  logic             start_w;
  logic             fin_w;

  always_comb begin
    tmr_d = tmr_q;
    if (!scan_en_i || (tmr_q == C_TMR_LAST)) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  assign tick_w  = scan_en_i && (tmr_q == C_TMR_LAST);
  assign start_w = tick_w || scan_req_i;
  assign fin_w   = (state_q == ST_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      raw_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pl_q    <= 1'b1;
      shcp_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_w && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
        pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_w) begin
            state_q <= ST_LOAD;
            div_q   <= '0;
            pl_q    <= 1'b0;
            shcp_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (div_q == C_DIV_LAST) begin
            state_q <= ST_SHIFT_LO;
            div_q   <= '0;
            idx_q   <= C_IDX_TOP;
            pl_q    <= 1'b1;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        // Sample just before the rising shift clock, while Q7 is settled.
        ST_SHIFT_LO: begin
          if (div_q == C_DIV_LAST) begin
            shift_q[idx_q] <= sft_q_i;
            state_q        <= ST_SHIFT_HI;
            div_q          <= '0;
            shcp_q         <= 1'b1;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        ST_SHIFT_HI: begin
          if (div_q == C_DIV_LAST) begin
            div_q  <= '0;
            shcp_q <= 1'b0;
            if (idx_q == '0) begin
              state_q <= ST_FIN;
            end else begin
              idx_q   <= idx_q - IW'(1);
              state_q <= ST_SHIFT_LO;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        ST_FIN: begin
          raw_q  <= shift_q;
          done_q <= 1'b1;
          pend_q <= 1'b0;
          div_q  <= '0;
          if (pend_q || start_w) begin
            state_q <= ST_LOAD;
            pl_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          pl_q    <= 1'b1;
          shcp_q  <= 1'b0;
        end
      endcase
    end
  end

  key_debounce #(
    .WIDTH    (WIDTH),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .fin_i   (fin_w),
    .shift_i (shift_q),
    .raw_i   (raw_q),
    .dout_o  (dout_o),
    .chg_o   (chg_o)
  );

  assign sft_pl_o   = pl_q;
  assign sft_shcp_o = shcp_q;
  assign raw_o      = raw_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;

endmodule : key_shift_rx
`default_nettype wire
